decode_stage: RTL and testbench

- Registered, parametrised RV32/RV64 instruction decode stage with a valid/ready handshake on both sides.
- Sits between fetch and register-read/execute.
- Splits the instruction into opcode, funct3, funct7, rd, rs1 and rs2.
- Also classifies the instruction format, generates the sign-extended immediate, flags illegal encodings and forwards the PC.
- A 2-entry skid buffer gives full throughput under backpressure; a flush input supports branch redirect.

---
 rtl/decode_pkg.sv | 66 ++++++
 rtl/decode_imm_gen.sv | 32 +++
 rtl/decode_stage.sv | 137 +++++++++++++
 tb/tb_decode_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode types: RV opcode map, instruction format codes, the decoded
// field bundle and the stage's occupancy states.
package decode_pkg;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    // Fixed-width decoded fields; imm and pc are parameter-sized, so the
    // stage wraps this bundle together with them in its own entry type.
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        fmt_e       fmt;
        logic       rd_we;
        logic       illegal;
    } dec_bundle_t;

    function automatic fmt_e opc_fmt(input logic [6:0] opc, input logic rv64);
        fmt_e f;
        case (opc)
            OPC_OP:                                  f = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR,
            OPC_SYSTEM, OPC_MISC_MEM:                f = FMT_I;
            OPC_STORE:                               f = FMT_S;
            OPC_BRANCH:                              f = FMT_B;
            OPC_LUI, OPC_AUIPC:                      f = FMT_U;
            OPC_JAL:                                 f = FMT_J;
            OPC_OP_32:                               f = rv64 ? FMT_R : FMT_NONE;
            OPC_OP_IMM_32:                           f = rv64 ? FMT_I : FMT_NONE;
            default:                                 f = FMT_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Immediate generator: builds the 32-bit RV immediate for the given format,
// then sign-extends it to XLEN. R and NONE yield zero.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    input  logic [2:0]      fmt_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt_e'(fmt_i))
            FMT_I: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            FMT_S: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            FMT_B: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                            inst_i[11:8], 1'b0};
            FMT_U: imm32 = {inst_i[31:12], 12'b0};
            FMT_J: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                            inst_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Size cast of a signed operand sign-extends for XLEN=64.
    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32/RV64 decode stage: combinational field decode feeding a
// 2-entry skid buffer with valid/ready on both sides and a flush input.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int HAS_M = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_rd_we,
    output logic            out_illegal,
    output logic [PC_W-1:0] out_pc
);

    typedef struct packed {
        dec_bundle_t     f;
        logic [XLEN-1:0] imm;
        logic [PC_W-1:0] pc;
    } entry_t;

    state_e state_q, state_d;
    entry_t main_q, main_d, skid_q, skid_d, dec;

    fmt_e            fmt;
    logic [XLEN-1:0] imm_raw;
    logic            f7_ok, illegal, accept, consume;

    // ---------------- field decode ----------------
    assign fmt   = opc_fmt(in_inst[6:0], XLEN == 64);
    assign f7_ok = (in_inst[31:25] == 7'h00) || (in_inst[31:25] == 7'h20) ||
                   ((HAS_M != 0) && (in_inst[31:25] == 7'h01));
    assign illegal = (in_inst[1:0] != 2'b11) || (fmt == FMT_NONE) ||
                     ((fmt == FMT_R) && !f7_ok);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst_i (in_inst),
        .fmt_i  (fmt),
        .imm_o  (imm_raw)
    );

    always_comb begin
        dec            = '0;
        dec.f.opcode   = in_inst[6:0];
        dec.f.funct3   = in_inst[14:12];
        dec.f.funct7   = in_inst[31:25];
        dec.f.rd       = in_inst[11:7];
        dec.f.rs1      = in_inst[19:15];
        dec.f.rs2      = in_inst[24:20];
        dec.f.fmt      = fmt;
        dec.f.illegal  = illegal;
        // SYSTEM/MISC-MEM are I-format but never produce a GPR write here.
        dec.f.rd_we    = !illegal && (in_inst[11:7] != 5'd0) &&
                         (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) &&
                         (in_inst[6:0] != OPC_SYSTEM) && (in_inst[6:0] != OPC_MISC_MEM);
        dec.imm        = illegal ? '0 : imm_raw;
        dec.pc         = in_pc;
    end

    // ---------------- skid buffer FSM ----------------
    assign in_ready  = (state_q != ST_SKID);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) begin
                    main_d  = dec;
                    state_d = ST_FULL;
                end
                ST_FULL: begin
                    if (accept && consume) begin
                        main_d = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = ST_SKID;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: if (consume) begin
                    main_d  = skid_q;
                    state_d = ST_FULL;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign out_opcode  = main_q.f.opcode;
    assign out_funct3  = main_q.f.funct3;
    assign out_funct7  = main_q.f.funct7;
    assign out_rd      = main_q.f.rd;
    assign out_rs1     = main_q.f.rs1;
    assign out_rs2     = main_q.f.rs2;
    assign out_fmt     = main_q.f.fmt;
    assign out_imm     = main_q.imm;
    assign out_rd_we   = main_q.f.rd_we;
    assign out_illegal = main_q.f.illegal;
    assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: three instances (RV32+M, RV64+M, RV32
// without M) share one stimulus stream; expected values are hand-computed.
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;

    logic        a_in_ready, a_out_valid, a_rd_we, a_illegal;
    logic [6:0]  a_opcode, a_funct7;
    logic [2:0]  a_funct3, a_fmt;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [31:0] a_imm, a_pc;

    logic        b_in_ready, b_out_valid, b_rd_we, b_illegal;
    logic [6:0]  b_opcode, b_funct7;
    logic [2:0]  b_funct3, b_fmt;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [63:0] b_imm;
    logic [31:0] b_pc;

    logic        c_in_ready, c_out_valid, c_rd_we, c_illegal;
    logic [6:0]  c_opcode, c_funct7;
    logic [2:0]  c_funct3, c_fmt;
    logic [4:0]  c_rd, c_rs1, c_rs2;
    logic [31:0] c_imm, c_pc;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .PC_W(32), .HAS_M(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_opcode(a_opcode), .out_funct3(a_funct3), .out_funct7(a_funct7), .out_rd(a_rd),
        .out_rs1(a_rs1), .out_rs2(a_rs2), .out_fmt(a_fmt), .out_imm(a_imm),
        .out_rd_we(a_rd_we), .out_illegal(a_illegal), .out_pc(a_pc));

    decode_stage #(.XLEN(64), .PC_W(32), .HAS_M(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_opcode(b_opcode), .out_funct3(b_funct3), .out_funct7(b_funct7), .out_rd(b_rd),
        .out_rs1(b_rs1), .out_rs2(b_rs2), .out_fmt(b_fmt), .out_imm(b_imm),
        .out_rd_we(b_rd_we), .out_illegal(b_illegal), .out_pc(b_pc));

    decode_stage #(.XLEN(32), .PC_W(32), .HAS_M(0)) dut_nm (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_opcode(c_opcode), .out_funct3(c_funct3), .out_funct7(c_funct7), .out_rd(c_rd),
        .out_rs1(c_rs1), .out_rs2(c_rs2), .out_fmt(c_fmt), .out_imm(c_imm),
        .out_rd_we(c_rd_we), .out_illegal(c_illegal), .out_pc(c_pc));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle accept of a word; output shows it right after the edge.
    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        tick(); tick();
        rst_n = 1'b1;

        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_in_ready",  64'(a_in_ready),  64'd1);
        chk("rst_opcode",    64'(a_opcode),    64'd0);
        chk("rst_imm",       64'(a_imm),       64'd0);
        chk("rst_pc",        64'(a_pc),        64'd0);

        // addi x1,x2,5
        out_ready = 1'b1;
        send(32'h00510093, 32'h100);
        chk("addi_valid",   64'(a_out_valid), 64'd1);
        chk("addi_opcode",  64'(a_opcode),    64'h13);
        chk("addi_rd",      64'(a_rd),        64'd1);
        chk("addi_rs1",     64'(a_rs1),       64'd2);
        chk("addi_funct3",  64'(a_funct3),    64'd0);
        chk("addi_fmt",     64'(a_fmt),       64'(FMT_I));
        chk("addi_imm",     64'(a_imm),       64'd5);
        chk("addi_rd_we",   64'(a_rd_we),     64'd1);
        chk("addi_illegal", 64'(a_illegal),   64'd0);
        chk("addi_pc",      64'(a_pc),        64'h100);

        // sw x1,-4(x2)
        send(32'hFE112E23, 32'h104);
        chk("sw_fmt",   64'(a_fmt),   64'(FMT_S));
        chk("sw_imm",   64'(a_imm),   64'hFFFFFFFC);
        chk("sw_rs1",   64'(a_rs1),   64'd2);
        chk("sw_rs2",   64'(a_rs2),   64'd1);
        chk("sw_rd_we", 64'(a_rd_we), 64'd0);

        // lui x5,0x12345 on RV32 and RV64
        send(32'h123452B7, 32'h108);
        chk("lui_fmt",    64'(a_fmt), 64'(FMT_U));
        chk("lui_imm",    64'(a_imm), 64'h12345000);
        chk("lui_rd",     64'(a_rd),  64'd5);
        chk("lui64_fmt",  64'(b_fmt), 64'(FMT_U));
        chk("lui64_imm",  b_imm,      64'h0000000012345000);

        // beq x0,x0,-4 : negative B immediate, sign-extended on RV64 too
        send(32'hFE000EE3, 32'h10C);
        chk("beq_fmt",   64'(a_fmt),   64'(FMT_B));
        chk("beq_imm",   64'(a_imm),   64'hFFFFFFFC);
        chk("beq64_imm", b_imm,        64'hFFFFFFFFFFFFFFFC);
        chk("beq_rd_we", 64'(a_rd_we), 64'd0);

        // jal x1,8
        send(32'h008000EF, 32'h110);
        chk("jal_fmt",   64'(a_fmt),   64'(FMT_J));
        chk("jal_imm",   64'(a_imm),   64'd8);
        chk("jal_rd_we", 64'(a_rd_we), 64'd1);

        // csrrw x1,0,x0 : SYSTEM never writes rd
        send(32'h000010F3, 32'h114);
        chk("csr_fmt",   64'(a_fmt),   64'(FMT_I));
        chk("csr_rd",    64'(a_rd),    64'd1);
        chk("csr_rd_we", 64'(a_rd_we), 64'd0);

        // all-zero word is illegal
        send(32'h00000000, 32'h118);
        chk("zero_illegal", 64'(a_illegal),  64'd1);
        chk("zero_imm",     64'(a_imm),      64'd0);
        chk("zero_rd_we",   64'(a_rd_we),    64'd0);
        chk("zero_fmt",     64'(a_fmt),      64'(FMT_NONE));
        chk("zero_valid",   64'(a_out_valid), 64'd1);

        // mul x0,x1,x2 : legal only with M
        send(32'h02208033, 32'h11C);
        chk("mul_illegal_m",   64'(a_illegal), 64'd0);
        chk("mul_illegal_nom", 64'(c_illegal), 64'd1);
        chk("mul_rs2",         64'(a_rs2),     64'd2);
        chk("mul_funct7_nom",  64'(c_funct7),  64'h01);

        // funct7=0x02 on OP is illegal everywhere
        send(32'h04000033, 32'h120);
        chk("f7bad_illegal", 64'(a_illegal), 64'd1);

        // OP-32 only exists on RV64
        send(32'h0000003B, 32'h124);
        chk("op32_illegal32", 64'(a_illegal), 64'd1);
        chk("op32_illegal64", 64'(b_illegal), 64'd0);
        chk("op32_fmt64",     64'(b_fmt),     64'(FMT_R));

        tick();
        chk("drain_valid", 64'(a_out_valid), 64'd0);

        // Backpressure: A then B back-to-back with out_ready low
        out_ready = 1'b0;
        send(32'h00A00093, 32'h200);
        send(32'h01400113, 32'h204);
        chk("bp_in_ready", 64'(a_in_ready),  64'd0);
        chk("bp_valid",    64'(a_out_valid), 64'd1);
        chk("bp_pc_a",     64'(a_pc),        64'h200);
        tick();
        chk("bp_hold_pc",  64'(a_pc),        64'h200);
        out_ready = 1'b1;
        tick();
        chk("bp_pc_b",     64'(a_pc),        64'h204);
        chk("bp_imm_b",    64'(a_imm),       64'd20);
        chk("bp_ready_b",  64'(a_in_ready),  64'd1);
        tick();
        chk("bp_empty",    64'(a_out_valid), 64'd0);

        // Flush in SKID with a same-cycle input
        out_ready = 1'b0;
        send(32'h00100093, 32'h300);
        send(32'h00200093, 32'h304);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00300093; in_pc = 32'h3FC;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_skid_valid", 64'(a_out_valid), 64'd0);
        chk("fl_skid_ready", 64'(a_in_ready),  64'd1);
        tick();
        chk("fl_skid_after", 64'(a_out_valid), 64'd0);

        // Flush in FULL where in_ready=1: input must still be dropped
        send(32'h00100093, 32'h400);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h404;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_full_valid", 64'(a_out_valid), 64'd0);
        tick();
        chk("fl_full_after", 64'(a_out_valid), 64'd0);

        // Throughput: 16 back-to-back instructions, one bundle per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_inst  = (32'(i) << 20) | 32'h13;
            in_pc    = 32'h1000 + 32'(i) * 4;
            tick();
            chk("tp_valid", 64'(a_out_valid), 64'd1);
            chk("tp_pc",    64'(a_pc),        64'h1000 + 64'(i) * 4);
            chk("tp_imm",   64'(a_imm),       64'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("tp_end_valid", 64'(a_out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
